// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter: round-robin arbiter sharing one byte-wide PISO serializer among N byte sources.
// Optional macro ARB_PRIO0_EN: requester 0 always wins IDLE arbitration when it is valid.
module serdes_tx_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = 2
) (
    input  logic             pclk_i,
    input  logic             rst_i,
    input  logic [8*N-1:0]   req_data_i,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [N-1:0]     grant_o,
    output logic [IDW-1:0]   gid_o,
    output logic             busy_o
);
    // state   | meaning
    // ST_IDLE | no grant; arbitrate among valid requesters
    // ST_BUSY | streaming bytes from requester r_gidx
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);
`ifdef ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW-1:0] r_gidx;
    logic [IDW-1:0] w_gidx_nxt;
    logic [7:0]     r_burst_cnt;
    logic [7:0]     w_burst_cnt_nxt;
    logic [7:0]     r_data;
    logic           r_valid;
    logic [IDW-1:0] r_gid;

    logic [IDW-1:0] w_pick;
    logic [IDW-1:0] w_cand;
    logic           w_pick_vld;
    logic [7:0]     w_gdata;
    logic           w_gvalid;
    logic           w_slot_free;
    logic           w_xfer;

    // Search order starts just after the last released requester.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_cand     = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IDW'((int'(r_ptr) + i) % N);
            if (!w_pick_vld && req_valid_i[w_cand]) begin
                w_pick     = w_cand;
                w_pick_vld = 1'b1;
            end
        end
        if (PRIO0 && req_valid_i[0]) begin
            w_pick     = '0;
            w_pick_vld = 1'b1;
        end
    end

    always_comb begin
        w_gdata  = '0;
        w_gvalid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (r_gidx == IDW'(k)) begin
                w_gdata  = req_data_i[8*k +: 8];
                w_gvalid = req_valid_i[k];
            end
        end
    end

    assign w_slot_free = !r_valid || ready_i;
    assign w_xfer      = (r_state == ST_BUSY) && w_gvalid && w_slot_free;

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        if (r_state == ST_BUSY) begin
            grant_o[r_gidx]     = 1'b1;
            req_ready_o[r_gidx] = w_slot_free;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gidx_nxt      = r_gidx;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt     = ST_BUSY;
                    w_gidx_nxt      = w_pick;
                    w_burst_cnt_nxt = '0;
                end
            end
            ST_BUSY: begin
                if (!w_gvalid) begin
                    w_state_nxt     = ST_IDLE;
                    w_ptr_nxt       = r_gidx;
                    w_burst_cnt_nxt = '0;
                end else if (w_xfer) begin
                    if (r_burst_cnt == LAST_CNT) begin
                        w_state_nxt     = ST_IDLE;
                        w_ptr_nxt       = r_gidx;
                        w_burst_cnt_nxt = '0;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDW'(N - 1);
            r_gidx      <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gidx      <= w_gidx_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Output register drains on its own, so valid_o may still be high in IDLE.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_gid   <= '0;
        end else if (w_xfer) begin
            r_data  <= w_gdata;
            r_valid <= 1'b1;
            r_gid   <= r_gidx;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign gid_o   = r_gid;
    assign busy_o  = (r_state == ST_BUSY);

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Directed self-checking bench for serdes_tx_arbiter with N=4, MAX_BURST=4.
module tb_serdes_tx_arbiter;
    localparam int N = 4;

    logic           pclk_i = 1'b0;
    logic           rst_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [7:0]     data_o;
    logic           valid_o;
    logic           ready_i;
    logic [N-1:0]   grant_o;
    logic [1:0]     gid_o;
    logic           busy_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_data [N][16];
    int         src_len [N];
    int         src_pos [N];
    logic [7:0] out_data [$];
    logic [1:0] out_gid  [$];
    logic [N-1:0] hs;

    serdes_tx_arbiter #(.N(4), .MAX_BURST(4), .IDW(2)) dut (
        .pclk_i      (pclk_i),
        .rst_i       (rst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .grant_o     (grant_o),
        .gid_o       (gid_o),
        .busy_o      (busy_o)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic drive_srcs();
        for (int k = 0; k < N; k++) begin
            if (src_pos[k] < src_len[k] && src_pos[k] < 16) begin
                req_valid_i[k]       = 1'b1;
                req_data_i[8*k +: 8] = src_data[k][src_pos[k]];
            end else begin
                req_valid_i[k]       = 1'b0;
                req_data_i[8*k +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load_src(input int k, input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) src_data[k][i] = base + 8'(i);
        src_len[k] = len;
        src_pos[k] = 0;
    endtask

    // One clock: record handshakes just before the edge, then advance the sources.
    task automatic cycle();
        #1;
        hs = req_valid_i & req_ready_o;
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            out_data.push_back(data_o);
            out_gid.push_back(gid_o);
        end
        @(posedge pclk_i);
        #1;
        for (int k = 0; k < N; k++) if (hs[k] === 1'b1) src_pos[k]++;
        drive_srcs();
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        drive_srcs();
        ready_i = 1'b1;
        rst_i   = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
        out_data.delete();
        out_gid.delete();
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) load_src(k, 8'h40 + 8'(16*k), 8);
        ready_i = 1'b1;
        rst_i   = 1'b1;
        drive_srcs();
        for (int r = 0; r < 2; r++) begin
            cycle();
            checks++;
            if ({grant_o, req_ready_o, valid_o, busy_o, data_o, gid_o} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: grant=%b ready=%b valid=%b busy=%b data=%h gid=%0d required all zero",
                         r, grant_o, req_ready_o, valid_o, busy_o, data_o, gid_o);
            end
        end
        rst_i = 1'b0;
        cycle();
        checks++;
        if (grant_o !== 4'b0001 || busy_o !== 1'b1 || req_ready_o !== 4'b0001 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL first_grant: grant=%b busy=%b ready=%b valid=%b required 0001 1 0001 0",
                     grant_o, busy_o, req_ready_o, valid_o);
        end
        cycle();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h40 || gid_o !== 2'd0) begin
            failures++;
            $display("FAIL first_byte: valid=%b data=%h gid=%0d required 1 40 0", valid_o, data_o, gid_o);
        end
        cycle();
        rst_i = 1'b1;
        cycle();
        checks++;
        if (valid_o !== 1'b0 || grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_burst: valid=%b grant=%b busy=%b required 0 0000 0", valid_o, grant_o, busy_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single_source();
        logic [11:0] vtrace;
        logic [11:0] exp_v;
        do_reset();
        load_src(2, 8'hA1, 8);
        drive_srcs();
        vtrace = '0;
        exp_v  = 12'b0111_1011_1100;
        for (int c = 0; c < 12; c++) begin
            cycle();
            vtrace = {vtrace[10:0], valid_o};
        end
        checks++;
        if (vtrace !== exp_v) begin
            failures++;
            $display("FAIL single_valid_trace: got %b required %b", vtrace, exp_v);
        end
        checks++;
        if (out_data.size() != 8) begin
            failures++;
            $display("FAIL single_count: got %0d bytes required 8", out_data.size());
        end
        for (int j = 0; j < out_data.size(); j++) begin
            checks++;
            if (out_data[j] !== 8'hA1 + 8'(j) || out_gid[j] !== 2'd2) begin
                failures++;
                $display("FAIL single_byte %0d: data=%h gid=%0d required %h 2", j, out_data[j], out_gid[j], 8'hA1 + 8'(j));
            end
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] glist [8];
        logic [N-1:0] prev;
        logic [N-1:0] exp_g;
        int gcount;
        do_reset();
        for (int k = 0; k < N; k++) load_src(k, 8'(16*k), 8);
        drive_srcs();
        gcount = 0;
        prev   = '0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (grant_o !== 4'b0000 && prev === 4'b0000 && gcount < 8) begin
                glist[gcount] = grant_o;
                gcount++;
            end
            prev = grant_o;
        end
        checks++;
        if (gcount < 5) begin
            failures++;
            $display("FAIL fair_grant_count: got %0d grants required at least 5", gcount);
        end
        for (int i = 0; i < 5 && i < gcount; i++) begin
            exp_g = 4'b0001 << (i % 4);
            checks++;
            if (glist[i] !== exp_g) begin
                failures++;
                $display("FAIL fair_grant %0d: got %b required %b", i, glist[i], exp_g);
            end
        end
        checks++;
        if (out_data.size() < 16) begin
            failures++;
            $display("FAIL fair_count: got %0d bytes required at least 16", out_data.size());
        end
        for (int j = 0; j < 16 && j < out_data.size(); j++) begin
            checks++;
            if (out_gid[j] !== 2'(j / 4) || out_data[j] !== 8'(16 * (j / 4) + (j % 4))) begin
                failures++;
                $display("FAIL fair_byte %0d: data=%h gid=%0d required %h %0d",
                         j, out_data[j], out_gid[j], 8'(16 * (j / 4) + (j % 4)), j / 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_src(1, 8'hB0, 6);
        drive_srcs();
        for (int c = 0; c < 3; c++) cycle();
        ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++;
            if (req_ready_o !== 4'b0000) begin
                failures++;
                $display("FAIL stall_ready %0d: got %b required 0000", s, req_ready_o);
            end
            cycle();
            checks++;
            if (data_o !== 8'hB1 || gid_o !== 2'd1 || valid_o !== 1'b1 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold %0d: data=%h gid=%0d valid=%b busy=%b required B1 1 1 1",
                         s, data_o, gid_o, valid_o, busy_o);
            end
        end
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) cycle();
        checks++;
        if (out_data.size() != 6) begin
            failures++;
            $display("FAIL stall_count: got %0d bytes required 6", out_data.size());
        end
        for (int j = 0; j < out_data.size(); j++) begin
            checks++;
            if (out_data[j] !== 8'hB0 + 8'(j) || out_gid[j] !== 2'd1) begin
                failures++;
                $display("FAIL stall_byte %0d: data=%h gid=%0d required %h 1", j, out_data[j], out_gid[j], 8'hB0 + 8'(j));
            end
        end
    endtask

    task automatic test_early_release();
        logic [7:0] exp_d;
        logic [1:0] exp_id;
        do_reset();
        load_src(1, 8'hC0, 2);
        load_src(2, 8'hD0, 4);
        drive_srcs();
        cycle();
        checks++;
        if (grant_o !== 4'b0010) begin
            failures++;
            $display("FAIL early_first_grant: got %b required 0010", grant_o);
        end
        cycle();
        cycle();
        cycle();
        checks++;
        if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
            failures++;
            $display("FAIL early_release_idle: busy=%b grant=%b required 0 0000", busy_o, grant_o);
        end
        cycle();
        checks++;
        if (grant_o !== 4'b0100) begin
            failures++;
            $display("FAIL early_next_grant: got %b required 0100", grant_o);
        end
        for (int c = 0; c < 6; c++) cycle();
        checks++;
        if (out_data.size() != 6) begin
            failures++;
            $display("FAIL early_count: got %0d bytes required 6", out_data.size());
        end
        for (int j = 0; j < out_data.size(); j++) begin
            exp_d  = (j < 2) ? 8'hC0 + 8'(j) : 8'hD0 + 8'(j - 2);
            exp_id = (j < 2) ? 2'd1 : 2'd2;
            checks++;
            if (out_data[j] !== exp_d || out_gid[j] !== exp_id) begin
                failures++;
                $display("FAIL early_byte %0d: data=%h gid=%0d required %h %0d", j, out_data[j], out_gid[j], exp_d, exp_id);
            end
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] exp_g;
`ifdef ARB_PRIO0_EN
        exp_g = 4'b0001;
`else
        exp_g = 4'b1000;
`endif
        do_reset();
        load_src(0, 8'hE0, 8);
        load_src(3, 8'hF0, 8);
        drive_srcs();
        cycle();
        checks++;
        if (grant_o !== 4'b0001) begin
            failures++;
            $display("FAIL prio_ptr3_grant: got %b required 0001", grant_o);
        end
        for (int c = 0; c < 4; c++) cycle();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_burst_release: busy=%b required 0", busy_o);
        end
        cycle();
        checks++;
        if (grant_o !== exp_g) begin
            failures++;
            $display("FAIL prio_ptr0_grant: got %b required %b", grant_o, exp_g);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        ready_i     = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        hs          = '0;
        for (int k = 0; k < N; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        test_reset();
        test_single_source();
        test_fairness();
        test_backpressure();
        test_early_release();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
